pipo_load_arbiter: RTL

Round-robin arbiter and load sequencer that shares one 8-bit parallel-in/parallel-out holding register among NUM_REQ requesters.
- Grants one requester at a time and muxes its data onto the register input.
- Issues a single-cycle load, holds the captured value for HOLD_CYCLES, then signals completion.
- Sits between requester blocks and the PIPO register instance: drives the register's enable, load and data inputs.

---
 rtl/pipo_arb_pkg.sv | 19 +
 rtl/pipo_rr_picker.sv | 38 +++
 rtl/pipo_load_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pipo_arb_pkg.sv
// Shared types and helpers for the PIPO load arbiter: FSM state encoding and index-width sizing.
package pipo_arb_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        LOAD    = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    // Width of an index into n items; never below one bit so n=1 still yields a legal vector.
    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipo_rr_picker.sv
// Combinational round-robin picker: first asserted request searching circularly from last_i+1.
module pipo_rr_picker
    import pipo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int OW = owner_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [OW-1:0]      last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [OW-1:0]      idx_o,
    output logic               valid_o
);

    int          cand;
    logic [OW-1:0] cand_idx;

    always_comb begin
        grant_o  = '0;
        idx_o    = last_i;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = OW'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o           = 1'b1;
                idx_o             = cand_idx;
                grant_o[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter and load sequencer sharing one PIPO holding register among NUM_REQ requesters.
// Optional readback check of the loaded value is built when PIPO_ARB_READBACK_EN is defined.
module pipo_load_arbiter
    import pipo_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                            Clk_In,
    input  logic                            Reset_In,
    input  logic                            Enable_In,
    input  logic [NUM_REQ-1:0]              Req_In,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   Data_In,
`ifdef PIPO_ARB_READBACK_EN
    input  logic [DATA_WIDTH-1:0]           Reg_Readback_In,
    output logic                            Mismatch_Out,
`endif
    output logic [NUM_REQ-1:0]              Grant_Out,
    output logic [NUM_REQ-1:0]              Done_Out,
    output logic [owner_width(NUM_REQ)-1:0] Owner_Out,
    output logic                            Busy_Out,
    output logic                            Reg_Enable_Out,
    output logic                            Reg_Load_Out,
    output logic [DATA_WIDTH-1:0]           Reg_Data_Out
);

    localparam int OW = owner_width(NUM_REQ);
    localparam int CW = owner_width(HOLD_CYCLES);
    localparam logic [OW-1:0] OWNER_RST = OW'(NUM_REQ - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(HOLD_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic [OW-1:0]           owner_q, owner_d;
    logic                    load_q, load_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [CW-1:0]           cnt_q, cnt_d;
`ifdef PIPO_ARB_READBACK_EN
    logic                    mismatch_q, mismatch_d;
`endif

    logic [NUM_REQ-1:0]      pick_grant;
    logic [OW-1:0]           pick_idx;
    logic                    pick_valid;

    pipo_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i   (Req_In),
        .last_i  (owner_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            done_q     <= '0;
            owner_q    <= OWNER_RST;
            load_q     <= 1'b0;
            data_q     <= '0;
            cnt_q      <= '0;
`ifdef PIPO_ARB_READBACK_EN
            mismatch_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            owner_q    <= owner_d;
            load_q     <= load_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
`ifdef PIPO_ARB_READBACK_EN
            mismatch_q <= mismatch_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        owner_d = owner_q;
        load_d  = 1'b0;
        data_d  = data_q;
        cnt_d   = cnt_q;
`ifdef PIPO_ARB_READBACK_EN
        mismatch_d = mismatch_q;
`endif
        // Dropping enable abandons the transaction silently; owner and data survive for the next round.
        if (!Enable_In) begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_d = pick_grant;
                        owner_d = pick_idx;
                        state_d = GRANT;
                    end
                end
                GRANT: begin
                    data_d = Data_In[owner_q*DATA_WIDTH +: DATA_WIDTH];
                    if (!Req_In[owner_q]) begin
                        grant_d = '0;
                        state_d = IDLE;
                    end else begin
                        load_d  = 1'b1;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end
                HOLD: begin
`ifdef PIPO_ARB_READBACK_EN
                    if (cnt_q == '0 && Reg_Readback_In != data_q) begin
                        mismatch_d = 1'b1;
                    end
`endif
                    if (cnt_q == CNT_LAST) begin
                        state_d = RELEASE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RELEASE: begin
                    done_d  = grant_q;
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
                default: begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign Grant_Out      = grant_q;
    assign Done_Out       = done_q;
    assign Owner_Out      = owner_q;
    assign Busy_Out       = (state_q != IDLE);
    assign Reg_Enable_Out = Enable_In;
    assign Reg_Load_Out   = load_q;
    assign Reg_Data_Out   = data_q;
`ifdef PIPO_ARB_READBACK_EN
    assign Mismatch_Out   = mismatch_q;
`endif

endmodule
